// File: rtl/ctrl_scheduler_if.sv
// ctrl_scheduler_if: control, configuration and event bus of the scheduler.
//   master : drives i_start/i_stop and the config write port, receives events
//   slave  : the scheduler itself
//   i_start, i_stop          level start / stop-at-end-of-period requests
//   i_cfg_we/addr/data       single-cycle config register write
//   o_slot[N_SLOTS]          per-slot compare-match pulses
//   o_ctrl                   OR of o_slot, aligned with it
//   o_wrap                   end-of-period pulse
//   o_busy, o_cnt            sequencing status and current counter
//   o_cfg_err                rejected config write pulse
interface ctrl_scheduler_if #(
    parameter int N_SLOTS = 4,
    parameter int CNT_W   = 5
);
    logic                 i_start;
    logic                 i_stop;
    logic                 i_cfg_we;
    logic [2:0]           i_cfg_addr;
    logic [CNT_W-1:0]     i_cfg_data;
    logic [N_SLOTS-1:0]   o_slot;
    logic                 o_ctrl;
    logic                 o_wrap;
    logic                 o_busy;
    logic [CNT_W-1:0]     o_cnt;
    logic                 o_cfg_err;

    modport master (
        output i_start, i_stop, i_cfg_we, i_cfg_addr, i_cfg_data,
        input  o_slot, o_ctrl, o_wrap, o_busy, o_cnt, o_cfg_err
    );

    modport slave (
        input  i_start, i_stop, i_cfg_we, i_cfg_addr, i_cfg_data,
        output o_slot, o_ctrl, o_wrap, o_busy, o_cnt, o_cfg_err
    );
endinterface

// File: rtl/ctrl_scheduler.sv
// ctrl_scheduler: periodic counter with N_SLOTS compare slots.
// A counter runs 0..period while busy; each enabled slot pulses one cycle
// after the counter equals its compare value, o_wrap pulses one cycle after
// the counter reaches period. Stop requests let the current period finish.
// Ports:
//   clock  single clock, all state on posedge
//   reset  synchronous active-high; restores config defaults, aborts a run
//   bus    ctrl_scheduler_if.slave (start/stop, config writes, event outputs)
// Config map: 0..N_SLOTS-1 cmp[k], 4 period, 5 enable mask, 6/7 reserved.
// The map assumes N_SLOTS <= 4 and N_SLOTS <= CNT_W.
module ctrl_scheduler #(
    parameter int N_SLOTS = 4,
    parameter int CNT_W   = 5
) (
    input  logic             clock,
    input  logic             reset,
    ctrl_scheduler_if.slave  bus
);

    localparam logic [2:0] ADDR_PERIOD = 3'd4;
    localparam logic [2:0] ADDR_MASK   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] default_cmp(input int k);
        case (k)
            0:       return CNT_W'(4);
            1:       return CNT_W'(20);
            2:       return CNT_W'(24);
            default: return CNT_W'(0);
        endcase
    endfunction

    state_e                          state_q, state_d;
    logic                            busy;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [CNT_W-1:0]                period_q;
    logic [N_SLOTS-1:0][CNT_W-1:0]   cmp_q;
    logic [N_SLOTS-1:0]              en_q;
    logic [N_SLOTS-1:0]              hit;
    logic [N_SLOTS-1:0]              slot_q;
    logic                            ctrl_q, wrap_q, cfg_err_q;
    logic                            at_end;
    logic                            cfg_wr;
    logic                            cfg_err_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.i_start && !bus.i_stop) state_d = ST_RUN;
            ST_RUN:      if (bus.i_stop)                 state_d = ST_STOPPING;
            ST_STOPPING: if (at_end)                     state_d = ST_IDLE;
            default:                                     state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // ---------------- period counter ----------------
    // cnt never exceeds period: period only changes in IDLE, where cnt is 0.
    assign at_end = (cnt_q == period_q);

    always_comb begin
        cnt_d = '0;
        if (busy && !at_end) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // ---------------- configuration ----------------
    assign cfg_wr    = bus.i_cfg_we && (state_q == ST_IDLE);
    assign cfg_err_d = bus.i_cfg_we && busy && (bus.i_cfg_addr <= ADDR_MASK);

    always_ff @(posedge clock) begin
        if (reset) begin
            period_q <= CNT_W'(31);
            en_q     <= N_SLOTS'(4'b0111);
            for (int k = 0; k < N_SLOTS; k++) cmp_q[k] <= default_cmp(k);
        end else if (cfg_wr) begin
            for (int k = 0; k < N_SLOTS; k++) begin
                if (bus.i_cfg_addr == 3'(k)) cmp_q[k] <= bus.i_cfg_data;
            end
            if (bus.i_cfg_addr == ADDR_PERIOD) period_q <= bus.i_cfg_data;
            if (bus.i_cfg_addr == ADDR_MASK)   en_q     <= bus.i_cfg_data[N_SLOTS-1:0];
        end
    end

    // ---------------- per-slot compare ----------------
    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign hit[k] = busy && en_q[k] && (cnt_q == cmp_q[k]);

        always_ff @(posedge clock) begin
            if (reset) slot_q[k] <= 1'b0;
            else       slot_q[k] <= hit[k];
        end
    end

    // ---------------- registered event outputs ----------------
    // o_ctrl is built from the same hit vector so it lines up with o_slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            ctrl_q    <= |hit;
            wrap_q    <= busy && at_end;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.o_slot    = slot_q;
    assign bus.o_ctrl    = ctrl_q;
    assign bus.o_wrap    = wrap_q;
    assign bus.o_busy    = busy;
    assign bus.o_cnt     = cnt_q;
    assign bus.o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ctrl_scheduler.sv
// Self-checking bench for ctrl_scheduler: a cycle model built from the
// scheduler's rules is compared against the DUT every negedge, and directed
// scenarios pin the model with hand-computed values.
module tb_ctrl_scheduler;

    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    ctrl_scheduler_if #(.N_SLOTS(4), .CNT_W(5)) bus ();

    ctrl_scheduler #(.N_SLOTS(4), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 finishing last period
    typedef struct packed {
        int              mode;
        int              cnt;
        int              period;
        logic [3:0][31:0] cmp;
        logic [3:0]      en;
        logic [3:0]      slot;
        logic            ctrl;
        logic            wrap;
        logic            err;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, bit rst, bit st, bit sp,
                                  bit we, int addr, int data);
        mdl_t n = m;
        bit   busy = (m.mode != 0);
        if (rst) begin
            n.mode = 0; n.cnt = 0; n.period = 31;
            n.cmp = {32'd0, 32'd24, 32'd20, 32'd4};
            n.en = 4'b0111; n.slot = '0;
            n.ctrl = 0; n.wrap = 0; n.err = 0;
            return n;
        end
        for (int k = 0; k < 4; k++)
            n.slot[k] = busy && m.en[k] && (m.cnt == int'(m.cmp[k]));
        n.ctrl = |n.slot;
        n.wrap = busy && (m.cnt == m.period);
        n.err  = we && busy && (addr <= 5);
        if (!busy && we) begin
            if (addr < 4)  n.cmp[addr] = 32'(data);
            if (addr == 4) n.period = data;
            if (addr == 5) n.en = data[3:0];
        end
        n.cnt = busy ? (m.cnt + 1) % (m.period + 1) : 0;
        if (m.mode == 0 && st && !sp)             n.mode = 1;
        else if (m.mode == 1 && sp)               n.mode = 2;
        else if (m.mode == 2 && m.cnt == m.period) n.mode = 0;
        return n;
    endfunction

    mdl_t m;
    bit   mv = 1'b0;

    always @(posedge clock) begin
        m  <= step(m, reset, bus.i_start, bus.i_stop, bus.i_cfg_we,
                   int'(bus.i_cfg_addr), int'(bus.i_cfg_data));
        mv <= mv | reset;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mv) begin
            check("m_slot",  32'(bus.o_slot),    32'(m.slot));
            check("m_ctrl",  32'(bus.o_ctrl),    32'(m.ctrl));
            check("m_wrap",  32'(bus.o_wrap),    32'(m.wrap));
            check("m_busy",  32'(bus.o_busy),    32'(m.mode != 0));
            check("m_cnt",   32'(bus.o_cnt),     32'(m.cnt));
            check("m_err",   32'(bus.o_cfg_err), 32'(m.err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input int addr, input int data);
        bus.i_cfg_we   = 1'b1;
        bus.i_cfg_addr = 3'(addr);
        bus.i_cfg_data = 5'(data);
        tick();
        bus.i_cfg_we   = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int i = 0;
        while (int'(bus.o_cnt) != v && i < 100) begin
            tick();
            i++;
        end
        check("wait_cnt", 32'(bus.o_cnt), 32'(v));
    endtask

    task automatic wait_idle();
        int i = 0;
        while (bus.o_busy && i < 100) begin
            tick();
            i++;
        end
        check("wait_idle", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_stop     = 1'b0;
        bus.i_cfg_we   = 1'b0;
        bus.i_cfg_addr = '0;
        bus.i_cfg_data = '0;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_cnt",  32'(bus.o_cnt),  32'd0);
        check("rst_slot", 32'(bus.o_slot), 32'd0);
        check("rst_wrap", 32'(bus.o_wrap), 32'd0);
        tick();

        // defaults: events at t+6, t+22, t+26, wrap at t+33, repeat at +32
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        check("def_cnt0", 32'(bus.o_cnt), 32'd0);
        repeat (5) tick();
        check("def_ctrl6", 32'(bus.o_ctrl), 32'd1);
        check("def_slot6", 32'(bus.o_slot), 32'h1);
        repeat (16) tick();
        check("def_slot22", 32'(bus.o_slot), 32'h2);
        repeat (4) tick();
        check("def_slot26", 32'(bus.o_slot), 32'h4);
        repeat (7) tick();
        check("def_wrap33", 32'(bus.o_wrap), 32'd1);
        check("def_cnt33",  32'(bus.o_cnt),  32'd0);
        repeat (5) tick();
        check("def_ctrl38", 32'(bus.o_ctrl), 32'd1);

        // rejected period write while running
        cfg(4, 5);
        check("run_err", 32'(bus.o_cfg_err), 32'd1);
        tick();
        check("run_err_clr", 32'(bus.o_cfg_err), 32'd0);

        // stop at cnt=10: period completes to 31
        wait_cnt(10);
        bus.i_stop = 1'b1;
        tick();
        wait_cnt(31);
        check("stop_busy31", 32'(bus.o_busy), 32'd1);
        tick();
        check("stop_idle", 32'(bus.o_busy), 32'd0);
        check("stop_wrap", 32'(bus.o_wrap), 32'd1);
        check("stop_cnt",  32'(bus.o_cnt),  32'd0);
        bus.i_stop = 1'b0;
        tick();

        // reset mid-run at cnt=15, overriding a config write
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        wait_cnt(15);
        reset = 1'b1;
        bus.i_cfg_we = 1'b1; bus.i_cfg_addr = 3'd4; bus.i_cfg_data = 5'd3;
        tick();
        reset = 1'b0;
        bus.i_cfg_we = 1'b0;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_cnt",  32'(bus.o_cnt),  32'd0);
        check("abort_slot", 32'(bus.o_slot), 32'd0);
        check("abort_ctrl", 32'(bus.o_ctrl), 32'd0);
        tick();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (5) tick();
        check("abort_def_slot", 32'(bus.o_slot), 32'h1);
        wait_cnt(31);
        tick();
        check("abort_def_wrap", 32'(bus.o_wrap), 32'd1);
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        wait_idle();

        // period=9, only slot 3 at cmp 9
        cfg(4, 9);
        cfg(3, 9);
        cfg(5, 8);
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (10) tick();
        check("p9_slot11", 32'(bus.o_slot), 32'h8);
        check("p9_wrap11", 32'(bus.o_wrap), 32'd1);
        cfg(6, 1);
        check("p9_rsvd_err", 32'(bus.o_cfg_err), 32'd0);
        repeat (9) tick();
        check("p9_slot21", 32'(bus.o_slot), 32'h8);
        check("p9_wrap21", 32'(bus.o_wrap), 32'd1);
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        wait_idle();

        // period=0: every busy cycle wraps and matches
        cfg(4, 0);
        cfg(3, 0);
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        tick();
        check("both_idle", 32'(bus.o_busy), 32'd0);
        bus.i_stop = 1'b0;
        tick();
        bus.i_start = 1'b0;
        check("p0_busy", 32'(bus.o_busy), 32'd1);
        check("p0_slot_first", 32'(bus.o_slot), 32'h0);
        tick();
        check("p0_slot", 32'(bus.o_slot), 32'h8);
        check("p0_wrap", 32'(bus.o_wrap), 32'd1);
        check("p0_ctrl", 32'(bus.o_ctrl), 32'd1);
        tick();
        check("p0_slot2", 32'(bus.o_slot), 32'h8);
        check("p0_cnt2",  32'(bus.o_cnt),  32'd0);
        bus.i_stop = 1'b1;
        tick();
        bus.i_stop = 1'b0;
        tick();
        check("p0_end_busy", 32'(bus.o_busy), 32'd0);
        check("p0_end_wrap", 32'(bus.o_wrap), 32'd1);
        check("p0_end_slot", 32'(bus.o_slot), 32'h8);
        tick();
        check("p0_quiet", 32'(bus.o_slot), 32'h0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
